// File: rtl/alu_seq.sv
// Handshaked sequential ALU: binary and logic ops finish in one edge, BCD ADD/SUB
// walks one nibble per edge, LSB nibble first.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_decimal,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_negative,
  output logic             out_zero,
  output logic             out_err
);

  localparam int unsigned Nibs = WIDTH / 4;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpSr  = 4'd2;
  localparam logic [3:0] OpSl  = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic             r_sub, r_c;
  logic [3:0]       r_nib;
  logic             r_carry, r_ovf, r_neg, r_zero, r_err;

  logic             w_dec_start;
  logic [WIDTH-1:0] w_bp;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_bin_y;
  logic             w_bin_c, w_bin_v, w_bin_err;

  logic [3:0]       w_na, w_nb, w_nib;
  logic [4:0]       w_s;
  logic [5:0]       w_d;
  logic             w_nc, w_last;
  logic [WIDTH-1:0] w_y_shift;

  assign w_dec_start = in_decimal && (in_op == OpAdd || in_op == OpSub);

  // Single-edge result for everything except BCD arithmetic.
  always_comb begin
    w_bp      = (in_op == OpSub) ? ~in_b : in_b;
    w_sum     = {1'b0, in_a} + {1'b0, w_bp} + (WIDTH+1)'(in_carry);
    w_bin_y   = '0;
    w_bin_c   = 1'b0;
    w_bin_v   = 1'b0;
    w_bin_err = 1'b0;
    case (in_op)
      OpAdd, OpSub: begin
        w_bin_y = w_sum[WIDTH-1:0];
        w_bin_c = w_sum[WIDTH];
        w_bin_v = (in_a[WIDTH-1] == w_bp[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OpSr: begin
        w_bin_y = {in_carry, in_a[WIDTH-1:1]};
        w_bin_c = in_a[0];
      end
      OpSl: begin
        w_bin_y = {in_a[WIDTH-2:0], in_carry};
        w_bin_c = in_a[WIDTH-1];
      end
      OpAnd:   w_bin_y = in_a & in_b;
      OpOr:    w_bin_y = in_a | in_b;
      OpXor:   w_bin_y = in_a ^ in_b;
      default: w_bin_err = 1'b1;
    endcase
  end

  // Operands shift right each BUSY edge, so the active nibble is always bits [3:0].
  always_comb begin
    w_na = r_a[3:0];
    w_nb = r_b[3:0];
    w_s  = {1'b0, w_na} + {1'b0, w_nb} + {4'b0, r_c};
    w_d  = {2'b0, w_na} - {2'b0, w_nb} - {5'b0, ~r_c};
    if (r_sub) begin
      if (w_d[5]) begin
        w_nib = w_d[3:0] + 4'd10;
        w_nc  = 1'b0;
      end else begin
        w_nib = w_d[3:0];
        w_nc  = 1'b1;
      end
    end else begin
      if (w_s > 5'd9) begin
        w_nib = w_s[3:0] + 4'd6;
        w_nc  = 1'b1;
      end else begin
        w_nib = w_s[3:0];
        w_nc  = 1'b0;
      end
    end
    w_y_shift = (r_y >> 4) | (WIDTH'(w_nib) << (WIDTH - 4));
    w_last    = (r_nib == 4'(Nibs - 1));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_next = w_dec_start ? StBusy : StDone;
      StBusy:  if (w_last) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_nib   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            if (w_dec_start) begin
              r_a   <= in_a;
              r_b   <= in_b;
              r_sub <= (in_op == OpSub);
              r_c   <= in_carry;
              r_nib <= '0;
            end else begin
              r_y     <= w_bin_y;
              r_carry <= w_bin_c;
              r_ovf   <= w_bin_v;
              r_neg   <= w_bin_y[WIDTH-1];
              r_zero  <= (w_bin_y == '0);
              r_err   <= w_bin_err;
            end
          end
        end
        StBusy: begin
          r_a   <= r_a >> 4;
          r_b   <= r_b >> 4;
          r_c   <= w_nc;
          r_nib <= r_nib + 4'd1;
          r_y   <= w_y_shift;
          if (w_last) begin
            r_carry <= w_nc;
            r_ovf   <= 1'b0;
            r_neg   <= w_y_shift[WIDTH-1];
            r_zero  <= (w_y_shift == '0);
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == StIdle);
  assign out_valid    = (r_state == StDone);
  assign out_y        = r_y;
  assign out_carry    = r_carry;
  assign out_overflow = r_ovf;
  assign out_negative = r_neg;
  assign out_zero     = r_zero;
  assign out_err      = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random ops, checked through a result scoreboard
// fed by an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W    = 8;
  localparam int unsigned Nibs = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [3:0]   in_op;
  logic         in_decimal;
  logic [W-1:0] in_a, in_b;
  logic         in_carry;
  logic         out_valid, out_ready;
  logic [W-1:0] out_y;
  logic         out_carry, out_overflow, out_negative, out_zero, out_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c, v, n, z, err;
  } res_t;

  res_t exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_decimal  (in_decimal),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_carry   (out_carry),
    .out_overflow(out_overflow),
    .out_negative(out_negative),
    .out_zero    (out_zero),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input int op, input bit dec, input longint a, input longint b,
                                 input bit cin);
    res_t   r;
    longint mask, y, c, da, db, s, d, bp, sa, sb, ss, half;
    bit     v, err;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    y = 0; c = 0; v = 0; err = 0;
    case (op)
      0, 1: begin
        if (dec) begin
          c = cin;
          for (int i = 0; i < Nibs; i++) begin
            da = (a >> (4 * i)) & 15;
            db = (b >> (4 * i)) & 15;
            if (op == 0) begin
              s = da + db + c;
              if (s > 9) begin y |= ((s + 6) & 15) << (4 * i); c = 1; end
              else       begin y |= s << (4 * i);              c = 0; end
            end else begin
              d = da - db - (1 - c);
              if (d < 0) begin y |= ((d + 10) & 15) << (4 * i); c = 0; end
              else       begin y |= d << (4 * i);               c = 1; end
            end
          end
        end else begin
          bp = (op == 1) ? (~b & mask) : b;
          s  = a + bp + cin;
          y  = s & mask;
          c  = (s >> W) & 1;
          sa = (a >= half) ? a - (mask + 1) : a;
          sb = (bp >= half) ? bp - (mask + 1) : bp;
          ss = sa + sb + cin;
          v  = (ss >= half) || (ss < -half);
        end
      end
      2: begin y = (longint'(cin) << (W - 1)) | (a >> 1); c = a & 1; end
      3: begin y = ((a << 1) | cin) & mask; c = (a >> (W - 1)) & 1; end
      4: y = a & b;
      5: y = a | b;
      6: y = a ^ b;
      default: err = 1;
    endcase
    r.y   = y[W-1:0];
    r.c   = c[0];
    r.v   = v;
    r.n   = r.y[W-1];
    r.z   = (r.y == '0);
    r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    res_t act, e;
    if (!reset && out_valid && out_ready) begin
      act = {out_y, out_carry, out_overflow, out_negative, out_zero, out_err};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_unexpected actual=%0h expected=none", act);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", act, e);
      end
    end
  end

  task automatic scramble();
    in_a       = W'($urandom);
    in_b       = W'($urandom);
    in_op      = 4'($urandom);
    in_decimal = 1'($urandom);
    in_carry   = 1'($urandom);
  endtask

  // Called #1 after a posedge (or mid-cycle); returns #1 after the accepting edge.
  task automatic accept(input logic [3:0] op, input bit dec, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit cin, input bit push);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_op = op; in_decimal = dec; in_a = a; in_b = b; in_carry = cin;
    in_valid = 1'b1;
    if (push) exp_q.push_back(model(op, dec, a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, exp_lat);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("return_idle", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+4:0] saved;
    int           op;
    bit           dec;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_decimal = 1'b0; in_a = '0; in_b = '0; in_carry = 1'b0;
    #12;
    chk("reset_handshake", {in_ready, out_valid}, 2'b10);
    chk("reset_outputs", {out_y, out_carry, out_overflow, out_negative, out_zero, out_err}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    accept(4'd0, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
    wait_done(0);
    chk("add_bin_y", out_y, 8'h80);
    chk("add_bin_cvnz", {out_carry, out_overflow, out_negative, out_zero}, 4'b0110);
    release_out(0);

    accept(4'd0, 1'b1, 8'h58, 8'h46, 1'b1, 1'b1);
    wait_done(Nibs);
    chk("add_dec_y", out_y, 8'h05);
    chk("add_dec_cv", {out_carry, out_overflow}, 2'b10);
    release_out(1);

    accept(4'd1, 1'b1, 8'h12, 8'h21, 1'b1, 1'b1);
    wait_done(Nibs);
    chk("sub_dec_y", out_y, 8'h91);
    chk("sub_dec_c", out_carry, 1'b0);
    release_out(0);

    accept(4'd1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1);
    wait_done(0);
    chk("sub_bin_y", out_y, 8'hFF);
    chk("sub_bin_cnv", {out_carry, out_negative, out_overflow}, 3'b010);
    release_out(0);

    accept(4'd2, 1'b0, 8'h81, 8'h55, 1'b1, 1'b1);
    wait_done(0);
    chk("sr_y", out_y, 8'hC0);
    chk("sr_cn", {out_carry, out_negative}, 2'b11);
    release_out(0);

    accept(4'd3, 1'b1, 8'h80, 8'hAA, 1'b0, 1'b1);
    wait_done(0);
    chk("sl_y", out_y, 8'h00);
    chk("sl_cz", {out_carry, out_zero}, 2'b11);
    release_out(0);

    // Backpressure in DONE while new requests are presented.
    accept(4'd6, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1);
    wait_done(0);
    saved = {out_y, out_carry, out_overflow, out_negative, out_zero, out_err};
    repeat (5) begin
      scramble();
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_stable", {out_y, out_carry, out_overflow, out_negative, out_zero, out_err}, saved);
      chk("hold_handshake", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0;
    release_out(0);
    @(posedge clk); #1;
    chk("no_stray_accept", out_valid, 1'b0);

    // Reset during the first BUSY cycle aborts; the next edge may accept.
    accept(4'd0, 1'b1, 8'h99, 8'h01, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_handshake", {in_ready, out_valid}, 2'b10);
    chk("abort_y", out_y, 0);
    #1;
    reset = 1'b0;
    accept(4'd0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
    wait_done(0);
    chk("post_reset_add_y", out_y, 8'h02);
    release_out(0);

    accept(4'd9, 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b1);
    wait_done(0);
    chk("illegal_err_z", {out_err, out_zero, out_y}, {2'b11, 8'h00});
    release_out(0);

    for (int i = 0; i < 300; i++) begin
      op  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 6) : $urandom_range(7, 15);
      dec = 1'($urandom);
      accept(4'(op), dec, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      wait_done(((op == 0 || op == 1) && dec) ? Nibs : 0);
      release_out($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operation-request handshake.
REQ-005 The block SHALL have port in_op, input, 4 bits, with encoding ADD=0, SUB=1, SR=2, SL=3, AND=4, OR=5, XOR=6; codes 7-15 are illegal.
REQ-006 The block SHALL have port in_decimal, input, 1 bit: selects BCD mode; it applies to ADD and SUB only.
REQ-007 The block SHALL have ports in_a and in_b (inputs, WIDTH bits: operands) and in_carry (input, 1 bit: carry in, where 1 means no borrow for SUB).
REQ-008 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.
REQ-009 The block SHALL have ports out_y (output, WIDTH bits: result) and out_carry, out_overflow, out_negative, out_zero, out_err (outputs, 1 bit each: flags).

Function
REQ-010 The block SHALL have FSM states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-011 An operation SHALL be accepted on an edge where in_valid=1 and in_ready=1, and operands, op, decimal flag and carry SHALL be latched at that edge.
REQ-012 While in_ready=0, the block SHALL ignore in_valid and all in_* signals.
REQ-013 For a binary op or any logic/shift op, the result SHALL be registered at the accepting edge and the FSM SHALL go IDLE->DONE, so out_valid is 1 in the following cycle.
REQ-014 For decimal ADD/SUB, the FSM SHALL go IDLE->BUSY and process one nibble per edge, LSB nibble first, with the nibble carry kept in a register; after WIDTH/4 nibble edges it SHALL enter DONE, so out_valid rises WIDTH/4 edges after the accepting edge.
REQ-015 In DONE, out_valid SHALL be 1 and all out_* SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE; there is no same-edge re-accept.
REQ-016 Binary ADD SHALL compute {C,Y}=A+B+Cin (WIDTH+1 bits); binary SUB SHALL compute A+~B+Cin, with C=1 meaning no borrow.
REQ-017 For binary ADD/SUB, V SHALL be (A[msb]==B'[msb]) && (Y[msb]!=A[msb]), where B'=B for ADD and ~B for SUB.
REQ-018 Decimal ADD SHALL, per nibble, compute s=a+b+c (5 bits); if s>9, the nibble SHALL be s+6 mod 16 with c=1, else s with c=0.
REQ-019 Decimal SUB SHALL, per nibble, compute d=a-b-(1-c); if d<0, the nibble SHALL be d+10 mod 16 with c=0, else d with c=1.
REQ-020 Non-BCD digits in decimal mode SHALL follow REQ-018/REQ-019 literally, with no error flag; out_carry SHALL be the final nibble carry, and V SHALL be 0 in decimal mode.
REQ-021 SR SHALL give Y={Cin,A[msb:1]} and C=A[0]; SL SHALL give Y={A[msb-1:0],Cin} and C=A[msb]; in_b SHALL be ignored for SR and SL.
REQ-022 AND, OR and XOR SHALL give Y=A op B with C=0.
REQ-023 V SHALL be 0 for all ops other than binary ADD/SUB.
REQ-024 For every op, N SHALL equal Y[msb] and Z SHALL equal (Y==0).
REQ-025 An illegal op SHALL complete in binary timing with Y=0, C=0, V=0, N=0, Z=1 and out_err=1; out_err SHALL be 0 for legal ops.
REQ-026 in_decimal SHALL be ignored for ops other than ADD and SUB.

Reset
REQ-027 When reset=1, the block SHALL asynchronously force FSM=IDLE, out_valid=0, in_ready=1, out_y=0, all flags=0, and nibble counter and carry register=0.
REQ-028 A reset asserted in BUSY or DONE SHALL abort the operation with no result delivered; the first accept is possible on the first edge after reset deasserts.

Verification (WIDTH=8)
REQ-029 Test: ADD A=0x7F, B=0x01, Cin=0, binary -> out_valid in the next cycle, Y=0x80, C=0, V=1, N=1, Z=0.
REQ-030 Test: decimal ADD A=0x58, B=0x46, Cin=1 -> Y=0x05, C=1, V=0, with out_valid rising 2 edges after accept.
REQ-031 Test: decimal SUB A=0x12, B=0x21, Cin=1 -> Y=0x91, C=0; then binary SUB A=0x00, B=0x01, Cin=1 -> Y=0xFF, C=0, N=1, V=0.
REQ-032 Test: SR A=0x81, Cin=1 -> Y=0xC0, C=1, N=1; then SL A=0x80, Cin=0 -> Y=0x00, C=1, Z=1.
REQ-033 Test: hold out_ready=0 for 5 cycles in DONE while driving in_valid with new operands -> out_* stable, in_ready=0, new request not accepted; out_ready=1 -> IDLE next cycle.
REQ-034 Test: pulse reset during the first BUSY cycle of a decimal ADD -> out_valid stays 0, in_ready=1 immediately, and the next accepted ADD 0x01+0x01 yields Y=0x02; in_op=9 -> out_err=1, Z=1.
